// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI word slave
package spi_pkg;

  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer with a parameterised reset value
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_word_slave.sv
// rtl/spi_word_slave.sv - SPI slave moving DATA_W-bit words with a tx holding register
// SPI_SLAVE_LOOPBACK_EN: underrun sends ~rx_data instead of all zeros.
module spi_word_slave
  import spi_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter logic CPOL   = 1'b0,
  parameter logic CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun,
  output logic              abort,
  input  logic              clr_status
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic ss_s, sck_s, mosi_s;
  logic ss_prev_q, sck_prev_q;

  spi_sync2 #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d_i(ss),   .q_o(ss_s));
  spi_sync2 #(.RST_VAL(CPOL)) u_sync_sck  (.clk(clk), .rst(rst), .d_i(sck),  .q_o(sck_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;
  logic              word_start;
  logic [DATA_W-1:0] default_word;

  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;

  assign lead_edge   = (sck_s != CPOL) && (sck_prev_q == CPOL);
  assign trail_edge  = (sck_s == CPOL) && (sck_prev_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ss_prev_q && !ss_s;
  assign ss_rise     = !ss_prev_q && ss_s;

`ifdef SPI_SLAVE_LOOPBACK_EN
  assign default_word = ~rx_data_q;
`else
  assign default_word = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q & ~clr_status;
    abort_d     = abort_q & ~clr_status;
    word_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = SHIFT;
          word_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q != '0) abort_d = 1'b1;
        end else begin
          word_start = done_q;
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[DATA_W-3:0], mosi_s};
            if (cnt_q == LAST_BIT) begin
              cnt_d     = '0;
              rx_data_d = {rx_sr_q, mosi_s};
              done_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // cnt_q == 0 on a shift edge is either the MSB-presenting edge or the
          // edge after the last bit, when the next word may already be loaded.
          if (shift_edge && (cnt_q != '0)) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_start) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d    = default_word;
        underrun_d = 1'b1;
      end
    end

    // Only possible when the holding register was empty, so it never collides
    // with a word-start transfer out of it.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_prev_q   <= 1'b1;
      sck_prev_q  <= CPOL;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      ss_prev_q   <= ss_s;
      sck_prev_q  <= sck_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign miso     = busy & tx_sr_q[DATA_W-1];
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = done_q;
  assign underrun = underrun_q;
  assign abort    = abort_q;

endmodule

// File: doc/spi_word_slave.md
SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter CPOL, default 0, meaning the idle level of sck.
REQ-003 SHALL have parameter CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports ss (input, 1, active-low select), sck (input, 1), mosi (input, 1) and miso (output, 1).
REQ-007 SHALL have port tx_data, input, DATA_W: the next word to transmit.
REQ-008 SHALL have ports tx_valid (input, 1) and tx_ready (output, 1): the tx holding-register handshake.
REQ-009 SHALL have ports rx_data (output, DATA_W: last complete received word) and rx_valid (output, 1: one-cycle strobe).
REQ-010 SHALL have port busy, output, 1: high while the FSM is in SHIFT.
REQ-011 SHALL have ports underrun and abort, output, 1 each: sticky status flags.
REQ-012 SHALL have port clr_status, input, 1: clears underrun and abort.

Function
REQ-013 ss, sck and mosi SHALL each pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized signals; clk SHALL be at least 8x the sck frequency.
REQ-014 Leading edge = synchronized sck leaving its CPOL level; trailing edge = returning to it; sample edge = leading if CPHA=0, else trailing; shift edge = the other edge.
REQ-015 The FSM SHALL have states IDLE and SHIFT: IDLE->SHIFT on synchronized ss falling; SHIFT->IDLE on synchronized ss rising.
REQ-016 Word start SHALL occur on IDLE->SHIFT entry and on the cycle after each completed word while ss stays low; back-to-back words SHALL be supported.
REQ-017 At word start the tx shift register SHALL load from the holding register if it is full, emptying it.
REQ-018 If the holding register is empty at word start, the tx shift register SHALL load the default word (REQ-033/034) and set underrun.
REQ-019 Data SHALL be MSB first; on each sample edge mosi SHALL shift into the rx shift register and a bit counter SHALL increment modulo DATA_W.
REQ-020 With CPHA=0, the MSB SHALL be on miso from word start and the tx register SHALL shift on each shift edge.
REQ-021 With CPHA=1, the tx register SHALL shift on each leading edge except the first of a word, which presents the MSB.
REQ-022 On the sample edge carrying bit DATA_W-1, rx_data SHALL update and rx_valid SHALL pulse high exactly one clk cycle later.
REQ-023 rx_data SHALL hold its value until the next complete word; there is no rx backpressure.
REQ-024 tx_ready SHALL be high when the holding register is empty; tx_valid&&tx_ready SHALL load tx_data into it.
REQ-025 A load coinciding with word start SHALL be written to the holding register after the transfer, so it is held for the next word.
REQ-026 ss rising mid-word (counter != 0) SHALL discard the partial word, set abort, suppress rx_valid, reset the counter and leave the holding register unchanged.
REQ-027 miso SHALL be 0 in IDLE.
REQ-028 If clr_status coincides with a flag-set event, the set SHALL win.

Reset
REQ-029 While rst is high, the FSM SHALL go to IDLE and the counter to 0, and the holding register SHALL be emptied.
REQ-030 While rst is high, the outputs SHALL be miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, underrun=0, abort=0.
REQ-031 Synchronizer flops SHALL reset to ss=1, sck=CPOL, mosi=0, so that no edge is detected after reset release.
REQ-032 Reset asserted mid-word SHALL abandon the word without setting abort; the next word SHALL begin only at a fresh ss falling edge.

Configuration
REQ-033 With macro SPI_SLAVE_LOOPBACK_EN defined, the underrun default word SHALL be the bitwise inverse of the current rx_data (0 inverted after reset).
REQ-034 Without SPI_SLAVE_LOOPBACK_EN, the underrun default word SHALL be all zeros.

Structure
REQ-035 Package spi_pkg SHALL hold the FSM state type (IDLE, SHIFT) and the DATA_W legal-range constants.
REQ-036 One sub-module, spi_sync2 (a 2-FF synchronizer with parameterised reset value), SHALL be instantiated three times.

Verification
REQ-037 Mode 0, DATA_W=8, tx 0xA5 preloaded, master sends 0x3C -> miso carries 0xA5, rx_data=0x3C, one rx_valid pulse.
REQ-038 Modes 1, 2 and 3 each with tx 0x81 and master 0x7E -> correct bits on both lines in every mode.
REQ-039 DATA_W=16, ss held low for two words 0x1234 then 0xBEEF, tx 0x0F0F then 0xF0F0 -> two rx_valid pulses; words and order correct.
REQ-040 Empty holding register, LOOPBACK_EN defined, previous rx 0x5A -> miso sends 0xA5 and underrun=1; without the macro -> 0x00 is sent.
REQ-041 ss raised after 5 of 8 bits -> abort=1, no rx_valid, rx_data unchanged, and the next full word is received correctly.
REQ-042 rst asserted at bit 3, then released -> every output at its REQ-030 value, abort=0, and a normal word follows.
